// File: rtl/not_pipe.sv
// rtl/not_pipe.sv - fixed-depth invert/mask transform pipeline with whole-pipe stall
// Each stage is a {valid, data} register; a stalled output freezes every stage.
module not_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int CNTW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  out_count
);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [CNTW-1:0]   r_count;

    logic              w_stall;
    logic              w_accept;
    logic              w_deliver;
    logic [WIDTH-1:0]  w_xform;

    assign w_stall   = r_valid[STAGES-1] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = r_valid[STAGES-1] & out_ready;

    // Mode 11 deliberately aliases mode 01 (plain inversion).
    always_comb begin
        w_xform = in_data;
        case (mode)
            2'b00:   w_xform = in_data;
            2'b01:   w_xform = ~in_data;
            2'b10:   w_xform = in_data ^ mask;
            default: w_xform = ~in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= w_accept;
            if (w_accept) begin
                r_data[0] <= w_xform;
            end
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    // Saturating delivery counter: sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_deliver && (r_count != '1)) begin
            r_count <= r_count + CNTW'(1);
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_count = r_count;

endmodule

// File: tb/tb_not_pipe.sv
// tb/tb_not_pipe.sv - table vectors, corner sequences and randomized model check for not_pipe
module tb_not_pipe;

    localparam int W = 8;
    localparam int S = 3;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   mode;
    logic [W-1:0] mask;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [C-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    not_pipe #(.WIDTH(W), .STAGES(S), .CNTW(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        bit           iv;
        logic [W-1:0] d;
        logic [1:0]   m;
        logic [W-1:0] k;
        bit           ordy;
        bit           erdy;
        bit           eov;
        logic [W-1:0] eod;
        int           ecnt;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic [W-1:0] d;
        int           rem;
    } flight_t;

    flight_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input logic [1:0] m,
                         input logic [W-1:0] k, input bit r);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        mask      = k;
        out_ready = r;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string t, input bit iv, input logic [W-1:0] d, input logic [1:0] m,
                       input logic [W-1:0] k, input bit ordy, input bit erdy, input bit eov,
                       input logic [W-1:0] eod, input int ecnt);
        vec_t v;
        v.tag = t; v.iv = iv; v.d = d; v.m = m; v.k = k; v.ordy = ordy;
        v.erdy = erdy; v.eov = eov; v.eod = eod; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    function automatic logic [W-1:0] xf(input logic [W-1:0] d, input logic [1:0] m,
                                        input logic [W-1:0] k);
        if (m == 2'b00)      return d;
        else if (m == 2'b10) return d ^ k;
        else                 return ~d;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, '0, 2'b00, '0, 1'b1);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        int  guard;
        bit  m_ov;
        bit  m_stall;
        int  m_cnt;
        bit  r_iv;
        logic [W-1:0] r_d;
        logic [W-1:0] r_k;
        logic [1:0]   r_m;

        // Reset held two edges with a word offered; none of it may survive.
        rst = 1'b1;
        drive(1'b1, 8'h55, 2'b01, 8'h00, 1'b1);
        step();
        chk("rst_in_ready_during", in_ready, 1'b1);
        step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_count", out_count, 16'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        drive(1'b0, '0, 2'b00, '0, 1'b1);
        for (int i = 0; i < S + 1; i++) begin
            step();
            chk("rst_no_survivor", out_valid, 1'b0);
        end

        // Mode sweep
        add("sweep0", 1, 8'hA5, 2'b00, 8'h0F, 1, 1, 0, 8'h00, 0);
        add("sweep1", 1, 8'hA5, 2'b01, 8'h0F, 1, 1, 0, 8'h00, 0);
        add("sweep2", 1, 8'hA5, 2'b10, 8'h0F, 1, 1, 1, 8'hA5, 0);
        add("sweep3", 1, 8'hA5, 2'b11, 8'h0F, 1, 1, 1, 8'h5A, 1);
        add("sweep4", 0, 8'h00, 2'b00, 8'h00, 1, 1, 1, 8'hAA, 2);
        add("sweep5", 0, 8'h00, 2'b00, 8'h00, 1, 1, 1, 8'h5A, 3);
        add("sweep6", 0, 8'h00, 2'b00, 8'h00, 1, 1, 0, 8'h00, 4);
        // Bubbles
        add("bub0", 1, 8'h00, 2'b01, 8'h00, 1, 1, 0, 8'h00, 4);
        add("bub1", 0, 8'h00, 2'b01, 8'h00, 1, 1, 0, 8'h00, 4);
        add("bub2", 1, 8'hFF, 2'b01, 8'h00, 1, 1, 1, 8'hFF, 4);
        add("bub3", 0, 8'h00, 2'b01, 8'h00, 1, 1, 0, 8'h00, 5);
        add("bub4", 0, 8'h00, 2'b01, 8'h00, 1, 1, 1, 8'h00, 5);
        add("bub5", 0, 8'h00, 2'b01, 8'h00, 1, 1, 0, 8'h00, 6);
        // Mode change with a word in flight
        add("mchg0", 1, 8'h3C, 2'b01, 8'h00, 1, 1, 0, 8'h00, 6);
        add("mchg1", 1, 8'h3C, 2'b00, 8'h00, 1, 1, 0, 8'h00, 6);
        add("mchg2", 0, 8'h00, 2'b00, 8'h00, 1, 1, 1, 8'hC3, 6);
        add("mchg3", 0, 8'h00, 2'b00, 8'h00, 1, 1, 1, 8'h3C, 7);
        add("mchg4", 0, 8'h00, 2'b00, 8'h00, 1, 1, 0, 8'h00, 8);
        // Backpressure: four stalled cycles while 0x05 is offered
        add("bp0",  1, 8'h01, 2'b01, 8'h00, 1, 1, 0, 8'h00, 8);
        add("bp1",  1, 8'h02, 2'b01, 8'h00, 1, 1, 0, 8'h00, 8);
        add("bp2",  1, 8'h03, 2'b01, 8'h00, 1, 1, 1, 8'hFE, 8);
        add("bp3",  1, 8'h04, 2'b01, 8'h00, 1, 1, 1, 8'hFD, 9);
        add("bp4",  1, 8'h05, 2'b01, 8'h00, 0, 0, 1, 8'hFD, 9);
        add("bp5",  1, 8'h05, 2'b01, 8'h00, 0, 0, 1, 8'hFD, 9);
        add("bp6",  1, 8'h05, 2'b01, 8'h00, 0, 0, 1, 8'hFD, 9);
        add("bp7",  1, 8'h05, 2'b01, 8'h00, 0, 0, 1, 8'hFD, 9);
        add("bp8",  1, 8'h05, 2'b01, 8'h00, 1, 1, 1, 8'hFC, 10);
        add("bp9",  1, 8'h06, 2'b01, 8'h00, 1, 1, 1, 8'hFB, 11);
        add("bp10", 1, 8'h07, 2'b01, 8'h00, 1, 1, 1, 8'hFA, 12);
        add("bp11", 1, 8'h08, 2'b01, 8'h00, 1, 1, 1, 8'hF9, 13);
        add("bp12", 0, 8'h00, 2'b01, 8'h00, 1, 1, 1, 8'hF8, 14);
        add("bp13", 0, 8'h00, 2'b01, 8'h00, 1, 1, 1, 8'hF7, 15);
        add("bp14", 0, 8'h00, 2'b01, 8'h00, 1, 1, 0, 8'h00, 16);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].m, vecs[i].k, vecs[i].ordy);
            #1;
            chk({vecs[i].tag, "_in_ready"}, in_ready, vecs[i].erdy);
            step();
            chk({vecs[i].tag, "_out_valid"}, out_valid, vecs[i].eov);
            if (vecs[i].eov) chk({vecs[i].tag, "_out_data"}, out_data, vecs[i].eod);
            chk({vecs[i].tag, "_out_count"}, out_count, vecs[i].ecnt);
        end

        // Reset with three words in flight
        for (int i = 0; i < S; i++) begin
            drive(1'b1, 8'(8'h10 + i), 2'b00, 8'h00, 1'b0);
            step();
        end
        chk("midrst_full", out_valid, 1'b1);
        rst = 1'b1;
        drive(1'b1, 8'h77, 2'b00, 8'h00, 1'b1);
        step();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_count", out_count, 16'h0);
        chk("midrst_in_ready", in_ready, 1'b1);
        drive(1'b0, '0, 2'b00, '0, 1'b1);
        n = 0;
        for (int i = 0; i < 2 * S; i++) begin
            step();
            if (out_valid) n++;
        end
        chk("midrst_none_emerge", n, 0);

        // Counter saturation
        do_reset();
        drive(1'b1, 8'h5A, 2'b00, 8'h00, 1'b1);
        n = 0;
        guard = 0;
        while (out_count != 16'hFFFF && guard < 70000) begin
            in_data = 8'($urandom);
            if (out_valid && out_ready) n++;
            step();
            guard++;
        end
        chk("sat_reached", out_count, 16'hFFFF);
        chk("sat_deliveries", n, 65535);
        n = 0;
        guard = 0;
        while (n < 2 && guard < 10) begin
            if (out_valid && out_ready) n++;
            step();
            guard++;
        end
        chk("sat_extra_deliveries", n, 2);
        chk("sat_hold", out_count, 16'hFFFF);

        // Randomized run against an in-order flight model
        do_reset();
        q.delete();
        m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_iv = ($urandom_range(0, 3) != 0);
            r_d  = 8'($urandom);
            r_m  = 2'($urandom);
            r_k  = 8'($urandom);
            drive(r_iv, r_d, r_m, r_k, ($urandom_range(0, 2) != 0));
            rst = ($urandom_range(0, 199) == 0);
            #1;
            m_ov    = (q.size() > 0) && (q[0].rem == 0);
            m_stall = m_ov && !out_ready;
            chk("rnd_in_ready", in_ready, !m_stall);
            step();
            if (rst) begin
                q.delete();
                m_cnt = 0;
            end else begin
                if (m_ov && out_ready) begin
                    void'(q.pop_front());
                    if (m_cnt != 65535) m_cnt++;
                end
                if (!m_stall) begin
                    foreach (q[k]) if (q[k].rem > 0) q[k].rem--;
                    if (r_iv) q.push_back('{d: xf(r_d, r_m, r_k), rem: S - 1});
                end
            end
            m_ov = (q.size() > 0) && (q[0].rem == 0);
            chk("rnd_out_valid", out_valid, m_ov);
            if (m_ov) chk("rnd_out_data", out_data, q[0].d);
            chk("rnd_out_count", out_count, m_cnt);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
